// File: rtl/param_pipe_shifter_if.sv
// param_pipe_shifter_if
//   Valid/ready bundle for param_pipe_shifter. WIDTH must match the shifter
//   instance that uses it.
//   Ports (signals):
//     in_valid/in_ready/in_data/in_shamt/in_op     : operand side
//     out_valid/out_ready/out_data[/out_carry]     : result side
//   Optional macro: SHIFTER_CARRY_EN adds out_carry.
//   modport master : producer of operands / consumer of results (testbench, ALU)
//   modport slave  : the shifter itself
interface param_pipe_shifter_if #(
  parameter int WIDTH = 32
);
  localparam int SHAMT_W = $clog2(WIDTH);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
`ifdef SHIFTER_CARRY_EN
  logic               out_carry;

  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_carry
  );
  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_carry
  );
`else
  modport master (
    output in_valid, in_data, in_shamt, in_op, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_shamt, in_op, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/param_pipe_shifter.sv
// param_pipe_shifter
//   Pipelined barrel shifter: log2(WIDTH) mux stages (1, 2, 4, ... bits),
//   a register after every STAGES_PER_REG stages, final stage registered.
//   Ops: 00 SLL, 01 SRL, 10 SRA, 11 ROR. Full-pipeline stall on backpressure.
//   Ports:
//     clk    : clock, rising edge
//     n_rst  : asynchronous active-low reset
//     bus    : param_pipe_shifter_if.slave (operand + result handshake)
//   Optional macro: SHIFTER_CARRY_EN adds out_carry (last bit shifted out).
module param_pipe_shifter #(
  parameter int WIDTH          = 32,
  parameter int STAGES_PER_REG = 2
) (
  input logic                 clk,
  input logic                 n_rst,
  param_pipe_shifter_if.slave bus
);
  localparam int SHAMT_W = $clog2(WIDTH);
  localparam int LAT     = (SHAMT_W + STAGES_PER_REG - 1) / STAGES_PER_REG;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  logic advance;

  for (genvar j = 0; j < LAT; j++) begin : g_grp
    localparam int LO = j * STAGES_PER_REG;
    localparam int HI = ((j + 1) * STAGES_PER_REG > SHAMT_W) ? SHAMT_W
                                                              : (j + 1) * STAGES_PER_REG;
    // Shift-amount bits this group is responsible for.
    localparam logic [SHAMT_W-1:0] MASK = SHAMT_W'(((1 << HI) - 1) ^ ((1 << LO) - 1));

    logic [WIDTH-1:0]   d_i;
    logic [WIDTH-1:0]   d_n;
    logic [WIDTH-1:0]   d_r;
    logic [SHAMT_W-1:0] sh_i;
    logic [SHAMT_W-1:0] en;
    logic [1:0]         op_i;
    logic               sg_i;
    logic               v_i;
    logic               v_r;
`ifdef SHIFTER_CARRY_EN
    logic               c_i;
    logic               c_n;
    logic               c_r;
    logic [WIDTH-1:0]   t;
`endif

    if (j == 0) begin : g_src
      assign d_i  = bus.in_data;
      assign sh_i = bus.in_shamt;
      assign op_i = bus.in_op;
      assign sg_i = bus.in_data[WIDTH-1];
      assign v_i  = bus.in_valid;
`ifdef SHIFTER_CARRY_EN
      assign c_i  = 1'b0;
`endif
    end else begin : g_src
      assign d_i  = g_grp[j-1].d_r;
      assign sh_i = g_grp[j-1].g_ctl.sh_r;
      assign op_i = g_grp[j-1].g_ctl.op_r;
      assign sg_i = g_grp[j-1].g_ctl.sg_r;
      assign v_i  = g_grp[j-1].v_r;
`ifdef SHIFTER_CARRY_EN
      assign c_i  = g_grp[j-1].c_r;
`endif
    end

    // Stages are applied in increasing weight, so the carry of the last
    // enabled stage is the last bit shifted out of the whole operation.
    always_comb begin
      d_n = d_i;
      en  = sh_i & MASK;
`ifdef SHIFTER_CARRY_EN
      c_n = c_i;
      t   = '0;
`endif
      for (int k = 0; k < SHAMT_W; k++) begin
        if (en[k]) begin
          case (op_i)
            OP_SLL: begin
`ifdef SHIFTER_CARRY_EN
              t   = d_n >> (WIDTH - (1 << k));
              c_n = t[0];
`endif
              d_n = d_n << (1 << k);
            end
            OP_SRL: begin
`ifdef SHIFTER_CARRY_EN
              t   = d_n >> ((1 << k) - 1);
              c_n = t[0];
`endif
              d_n = d_n >> (1 << k);
            end
            OP_SRA: begin
`ifdef SHIFTER_CARRY_EN
              t   = d_n >> ((1 << k) - 1);
              c_n = t[0];
`endif
              // Fill from the original operand's sign, carried down the pipe.
              d_n = (d_n >> (1 << k)) | ({WIDTH{sg_i}} << (WIDTH - (1 << k)));
            end
            default: begin
              d_n = (d_n >> (1 << k)) | (d_n << (WIDTH - (1 << k)));
`ifdef SHIFTER_CARRY_EN
              c_n = d_n[WIDTH-1];
`endif
            end
          endcase
        end
      end
    end

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        d_r <= '0;
        v_r <= 1'b0;
`ifdef SHIFTER_CARRY_EN
        c_r <= 1'b0;
`endif
      end else if (advance) begin
        d_r <= d_n;
        v_r <= v_i;
`ifdef SHIFTER_CARRY_EN
        c_r <= c_n;
`endif
      end
    end

    // The last group has no consumer for shamt/op/sign, so they stop here.
    if (j < LAT - 1) begin : g_ctl
      logic [SHAMT_W-1:0] sh_r;
      logic [1:0]         op_r;
      logic               sg_r;

      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          sh_r <= '0;
          op_r <= '0;
          sg_r <= 1'b0;
        end else if (advance) begin
          sh_r <= sh_i;
          op_r <= op_i;
          sg_r <= sg_i;
        end
      end
    end
  end

  assign advance      = !g_grp[LAT-1].v_r || bus.out_ready;
  assign bus.in_ready = advance;
  assign bus.out_valid = g_grp[LAT-1].v_r;
  assign bus.out_data  = g_grp[LAT-1].d_r;
`ifdef SHIFTER_CARRY_EN
  assign bus.out_carry = g_grp[LAT-1].c_r;
`endif

endmodule

// File: tb/tb_param_pipe_shifter.sv
module tb_param_pipe_shifter;
  localparam int WIDTH = 32;
  localparam int LAT   = 3;

  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  param_pipe_shifter_if #(.WIDTH(WIDTH)) bus ();

  param_pipe_shifter #(.WIDTH(WIDTH), .STAGES_PER_REG(2)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        c;
  } exp_t;

  int          vectors     = 0;
  int          miscompares = 0;
  exp_t        expq[$];
  logic        got;
  logic [31:0] got_data;
  logic        got_carry;
  int          cyc = 0;
  int          nout = 0;
  int          first_out = -1;
  int          last_out = -1;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_data;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Whole-operation reference: shift by n in one go.
  function automatic exp_t model(input logic [31:0] d, input int n, input logic [1:0] op);
    exp_t        e;
    logic [31:0] r;
    logic [31:0] tmp;
    case (op)
      2'd0:    r = d << n;
      2'd1:    r = d >> n;
      2'd2:    r = $signed(d) >>> n;
      default: r = (n == 0) ? d : ((d >> n) | (d << (32 - n)));
    endcase
    e.d = r;
    if (n == 0) e.c = 1'b0;
    else begin
      case (op)
        2'd0:    begin tmp = d >> (32 - n); e.c = tmp[0]; end
        2'd1,
        2'd2:    begin tmp = d >> (n - 1);  e.c = tmp[0]; end
        default: e.c = r[31];
      endcase
    end
    return e;
  endfunction

  task automatic step(input logic v, input logic [31:0] d, input logic [4:0] sh,
                      input logic [1:0] op, input logic ordy);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_shamt  = sh;
    bus.in_op     = op;
    bus.out_ready = ordy;
    #1;
    cyc++;
    if (prev_hold) begin
      chk("hold_valid", 64'(bus.out_valid), 64'(1'b1));
      chk("hold_data", 64'(bus.out_data), 64'(prev_data));
    end
    prev_hold = bus.out_valid && !bus.out_ready;
    prev_data = bus.out_data;
    got = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      got      = 1'b1;
      got_data = bus.out_data;
      got_carry = 1'b0;
`ifdef SHIFTER_CARRY_EN
      got_carry = bus.out_carry;
`endif
      nout++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
      if (expq.size() == 0) chk("spurious_out", 64'(1'b1), 64'(1'b0));
      else begin
        e = expq.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(e.d));
`ifdef SHIFTER_CARRY_EN
        chk("out_carry", 64'(bus.out_carry), 64'(e.c));
`endif
      end
    end
    if (v && bus.in_ready) expq.push_back(model(d, int'(sh), op));
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 5'd0, 2'd0, 1'b1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && expq.size() > 0; i++) idle();
    chk("drain_empty", 64'(expq.size()), 64'(0));
  endtask

  task automatic send_one(input string tag, input logic [31:0] d, input logic [4:0] sh,
                          input logic [1:0] op, input logic [31:0] exp_d, input logic exp_c);
    int lat;
    step(1'b1, d, sh, op, 1'b1);
    lat = 0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      idle();
      if (got) lat = i;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(LAT));
    chk({tag, "_data"}, 64'(got_data), 64'(exp_d));
`ifdef SHIFTER_CARRY_EN
    chk({tag, "_carry"}, 64'(got_carry), 64'(exp_c));
`else
    if (exp_c === 1'bx) $display("unused carry");
`endif
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_shamt  = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b1;
    got = 1'b0; got_data = '0; got_carry = 1'b0; prev_data = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
`ifdef SHIFTER_CARRY_EN
    chk("rst_out_carry", 64'(bus.out_carry), 64'(1'b0));
`endif
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("post_rst_in_ready", 64'(bus.in_ready), 64'(1'b1));

    // Directed operations
    send_one("sra4",  32'h8000_0000, 5'd4,  2'd2, 32'hF800_0000, 1'b0);
    send_one("ror1",  32'h0000_0001, 5'd1,  2'd3, 32'h8000_0000, 1'b1);
    send_one("srl1",  32'h0000_0001, 5'd1,  2'd1, 32'h0000_0000, 1'b1);
    send_one("sll28", 32'h0000_00FF, 5'd28, 2'd0, 32'hF000_0000, 1'b1);
    send_one("sll0",  32'h0000_00FF, 5'd0,  2'd0, 32'h0000_00FF, 1'b0);
    send_one("sra31", 32'h8000_1234, 5'd31, 2'd2, 32'hFFFF_FFFF, 1'b0);
    send_one("sll31", 32'h0000_0001, 5'd31, 2'd0, 32'h8000_0000, 1'b0);
    send_one("ror0",  32'hA5A5_0F0F, 5'd0,  2'd3, 32'hA5A5_0F0F, 1'b0);

    // Back-to-back stream, out_ready high
    nout = 0; first_out = -1; last_out = -1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'(i), 5'd1, 2'd0, 1'b1);
      chk("stream_in_ready", 64'(bus.in_ready), 64'(1'b1));
    end
    drain();
    chk("stream_count", 64'(nout), 64'(8));
    chk("stream_consecutive", 64'(last_out - first_out), 64'(7));

    // Stall for 4 cycles after the first result
    begin
      logic [31:0] held;
      int          seen;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
        step(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'b1);
        if (got) seen = 1;
      end
      chk("stall_first_seen", 64'(seen), 64'(1));
      step(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'b0);
      held = bus.out_data;
      for (int i = 0; i < 4; i++) begin
        if (i > 0)
          step(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'b0);
        chk("stall_in_ready", 64'(bus.in_ready), 64'(1'b0));
        chk("stall_out_valid", 64'(bus.out_valid), 64'(1'b1));
        chk("stall_out_data", 64'(bus.out_data), 64'(held));
      end
      drain();
    end

    // Reset with three operands in flight
    for (int i = 0; i < 3; i++)
      step(1'b1, $urandom, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), 1'b1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", 64'(bus.out_valid), 64'(1'b1));
    n_rst = 1'b0;
    #1;
    chk("async_rst_out_valid", 64'(bus.out_valid), 64'(1'b0));
    chk("async_rst_in_ready", 64'(bus.in_ready), 64'(1'b1));
    expq.delete();
    prev_hold = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < LAT; i++) begin
      idle();
      chk("post_rst_no_out", 64'(bus.out_valid), 64'(1'b0));
    end
    send_one("after_rst", 32'h1234_5678, 5'd8, 2'd3, 32'h7812_3456, 1'b0);

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 3) != 0), $urandom, 5'($urandom_range(0, 31)),
           2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    drain();
    repeat (5) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/param_pipe_shifter.md
Name: param_pipe_shifter

Overview:
- Parametrised, pipelined barrel shifter for the ALU datapath.
- Built from log2(WIDTH) mux stages: 1, 2, 4, … bit positions.
- Supports logical left, logical right, arithmetic right and rotate right.
- Pipeline registers sit after every STAGES_PER_REG mux stages. The block uses a valid/ready handshake with full-pipeline stall on backpressure.

Parameters:
- WIDTH, 32, data width; power of two, 8..64.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, not overridden.
- STAGES_PER_REG, 2, number of mux stages between pipeline registers; range 1..SHAMT_W.

Ports:
- clk  input  1  clock; all state on rising edge.
- n_rst  input  1  asynchronous active-low reset.
- in_valid  input  1  input operand valid.
- in_ready  output  1  block can accept operand this cycle.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHAMT_W  shift amount.
- in_op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  WIDTH  shifted result.
- out_carry  output  1  last bit shifted out; present only with SHIFTER_CARRY_EN.

Behaviour:
- Reset: asynchronous on n_rst low, sync release.
  - All pipeline valid bits = 0, data/shamt/op registers = 0.
  - out_valid = 0, out_data = 0, out_carry = 0.
  - in_ready = 1 during and after reset.
- Latency: LAT = ceil(SHAMT_W / STAGES_PER_REG) cycles, with the final stage registered. WIDTH=32, STAGES_PER_REG=2 gives LAT=3.
- Accepted transfer at cycle t (in_valid && in_ready) → out_valid at t+LAT if no stall occurs in between.
- Throughput: one result per cycle when out_ready is held high.
- Stall rule: advance = !out_valid || out_ready, and in_ready = advance.
  - When advance = 0, every pipeline register holds.
  - Bubbles are not collapsed.
- out_data, out_valid and out_carry must stay stable while out_valid && !out_ready (AXI-style hold).
- Stage k (bit weight 2^k) is enabled by shamt[k]. Shamt and op are carried along the pipe with the data.
- Fill rules per stage:
  - SLL fills LSBs with 0.
  - SRL fills MSBs with 0.
  - SRA fills MSBs with in_data[WIDTH-1] of the original operand; the sign bit is carried down the pipe.
  - ROR wraps the low bits to the MSBs.
- shamt = 0: out_data = in_data for every op.
- Maximum shamt WIDTH-1:
  - SRA of a negative operand gives all ones.
  - SLL of 1 gives 1<<(WIDTH-1).
- A register-stage valid bit is cleared when it advances with no incoming valid.
- Reset mid-operation: all in-flight results are discarded; no result emerges after reset release.

Optional Feature:
- Macro: SHIFTER_CARRY_EN.
- When defined:
  - out_carry port exists and is registered alongside out_data.
  - For shamt = n > 0: SLL → in_data[WIDTH-n]; SRL/SRA → in_data[n-1]; ROR → out_data[WIDTH-1].
  - For n = 0: out_carry = 0.
  - Carry is computed per stage and merged down the pipe, so LAT is unchanged.
- When undefined: out_carry port and its registers are absent, with no other change.

Test Plan (WIDTH=32, STAGES_PER_REG=2, LAT=3):
- Reset release, then in_data=0x80000000, op=SRA, shamt=4, out_ready=1 → out_data=0xF8000000 exactly 3 cycles after accept; out_carry=0.
- in_data=0x00000001, op=ROR, shamt=1 → out_data=0x80000000, out_carry=1. Same operand with op=SRL → out_data=0, carry=1.
- in_data=0x000000FF, op=SLL, shamt=28 → out_data=0xF0000000, carry=1. Same operand with shamt=0 → out_data=0x000000FF, carry=0.
- Back-to-back stream of 8 operands (0x1..0x8, SLL by 1), out_ready=1 → 8 consecutive valid outputs 0x2..0x10, in_ready never low.
- Stream with out_ready held low for 4 cycles after the first result appears:
  - in_ready=0 during the stall.
  - out_data held at the same value.
  - No result lost or duplicated; order preserved once out_ready=1.
- n_rst asserted while 3 operands are in flight:
  - out_valid drops immediately (asynchronously).
  - After release, no output until a new accept, and out_valid=0 for the next 3 cycles.
